// File: rtl/uart_transceiver.sv
// uart_transceiver: full-duplex 8N1 UART with independent RX and TX paths.
// Baud timing comes from ClkFrequency/Baud; BIT_CLKS must be >= 16.
// Optional macro UART_FRAME_ERR_EN adds the RxD_frame_err pulse output.
`timescale 1ns/1ps

module uart_transceiver #(
    parameter int unsigned ClkFrequency = 10000000,
    parameter int unsigned Baud         = 19200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RxD,
    output logic       RxD_data_ready,
    output logic [7:0] RxD_data,
    output logic       TxD,
    input  logic       TxD_start,
    input  logic [7:0] TxD_data,
    output logic       TxD_busy
`ifdef UART_FRAME_ERR_EN
    ,
    output logic       RxD_frame_err
`endif
);

    localparam int unsigned BIT_CLKS = (ClkFrequency + Baud / 2) / Baud;
    localparam int unsigned CNT_W    = $clog2(BIT_CLKS);

    // Counters expire at zero, so a reload of BIT_CLKS-1 gives BIT_CLKS clocks per state
    localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(BIT_CLKS - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BIT_CLKS / 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] TxIdle  = 2'd0;
    localparam logic [1:0] TxStart = 2'd1;
    localparam logic [1:0] TxData  = 2'd2;
    localparam logic [1:0] TxStop  = 2'd3;

    localparam logic [2:0] RxIdle  = 3'd0;
    localparam logic [2:0] RxStart = 3'd1;
    localparam logic [2:0] RxData  = 3'd2;
    localparam logic [2:0] RxStop  = 3'd3;
    localparam logic [2:0] RxBreak = 3'd4;

    logic [1:0]       r_tx_state;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [2:0]       r_tx_bit;
    logic [7:0]       r_tx_shift;
    logic             r_txd;
    logic             r_tx_busy;
    logic             w_tx_tick;

    logic             r_rx_sync1;
    logic             r_rx_sync2;
    logic [2:0]       r_rx_state;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [2:0]       r_rx_bit;
    logic [7:0]       r_rx_shift;
    logic [7:0]       r_rx_data;
    logic             r_rx_ready;
    logic             w_rx;
    logic             w_rx_tick;
`ifdef UART_FRAME_ERR_EN
    logic             r_frame_err;
`endif

    assign w_tx_tick = (r_tx_cnt == '0);
    assign w_rx_tick = (r_rx_cnt == '0);
    assign w_rx      = r_rx_sync2;

    assign TxD            = r_txd;
    assign TxD_busy       = r_tx_busy;
    assign RxD_data       = r_rx_data;
    assign RxD_data_ready = r_rx_ready;
`ifdef UART_FRAME_ERR_EN
    assign RxD_frame_err  = r_frame_err;
`endif

    // Transmitter: one state per bit time, TxD registered straight from the FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= TxIdle;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
            r_tx_busy  <= 1'b0;
        end else begin
            unique case (r_tx_state)
                TxIdle: begin
                    if (TxD_start) begin
                        r_tx_shift <= TxD_data;
                        r_txd      <= 1'b0;
                        r_tx_busy  <= 1'b1;
                        r_tx_cnt   <= CNT_BIT;
                        r_tx_state <= TxStart;
                    end
                end
                TxStart: begin
                    if (w_tx_tick) begin
                        r_txd      <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_tx_bit   <= '0;
                        r_tx_cnt   <= CNT_BIT;
                        r_tx_state <= TxData;
                    end else begin
                        r_tx_cnt <= r_tx_cnt - CNT_ONE;
                    end
                end
                TxData: begin
                    if (w_tx_tick) begin
                        r_tx_cnt <= CNT_BIT;
                        if (r_tx_bit == 3'd7) begin
                            r_txd      <= 1'b1;
                            r_tx_state <= TxStop;
                        end else begin
                            r_txd      <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_tx_bit   <= r_tx_bit + 3'd1;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt - CNT_ONE;
                    end
                end
                TxStop: begin
                    if (w_tx_tick) begin
                        r_tx_busy  <= 1'b0;
                        r_tx_state <= TxIdle;
                    end else begin
                        r_tx_cnt <= r_tx_cnt - CNT_ONE;
                    end
                end
                default: r_tx_state <= TxIdle;
            endcase
        end
    end

    // Two-flop synchronizer for the asynchronous RxD pin; resets to line idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_sync1 <= 1'b1;
            r_rx_sync2 <= 1'b1;
        end else begin
            r_rx_sync1 <= RxD;
            r_rx_sync2 <= r_rx_sync1;
        end
    end

    // Receiver: half-bit delay to the start-bit centre, then sample every bit centre
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state  <= RxIdle;
            r_rx_cnt    <= '0;
            r_rx_bit    <= '0;
            r_rx_shift  <= '0;
            r_rx_data   <= '0;
            r_rx_ready  <= 1'b0;
`ifdef UART_FRAME_ERR_EN
            r_frame_err <= 1'b0;
`endif
        end else begin
            r_rx_ready  <= 1'b0;
`ifdef UART_FRAME_ERR_EN
            r_frame_err <= 1'b0;
`endif
            unique case (r_rx_state)
                RxIdle: begin
                    if (!w_rx) begin
                        r_rx_cnt   <= CNT_HALF;
                        r_rx_state <= RxStart;
                    end
                end
                RxStart: begin
                    if (w_rx_tick) begin
                        if (w_rx) begin
                            // Line back high at the start-bit centre: treat as a glitch
                            r_rx_state  <= RxIdle;
`ifdef UART_FRAME_ERR_EN
                            r_frame_err <= 1'b1;
`endif
                        end else begin
                            r_rx_cnt   <= CNT_BIT;
                            r_rx_bit   <= '0;
                            r_rx_state <= RxData;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - CNT_ONE;
                    end
                end
                RxData: begin
                    if (w_rx_tick) begin
                        r_rx_shift <= {w_rx, r_rx_shift[7:1]};
                        r_rx_cnt   <= CNT_BIT;
                        r_rx_bit   <= r_rx_bit + 3'd1;
                        if (r_rx_bit == 3'd7) begin
                            r_rx_state <= RxStop;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - CNT_ONE;
                    end
                end
                RxStop: begin
                    if (w_rx_tick) begin
                        if (w_rx) begin
                            r_rx_data  <= r_rx_shift;
                            r_rx_ready <= 1'b1;
                            r_rx_state <= RxIdle;
                        end else begin
                            // Framing error: hold off until the line idles so a break is not a frame
                            r_rx_state  <= RxBreak;
`ifdef UART_FRAME_ERR_EN
                            r_frame_err <= 1'b1;
`endif
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - CNT_ONE;
                    end
                end
                RxBreak: begin
                    if (w_rx) begin
                        r_rx_state <= RxIdle;
                    end
                end
                default: r_rx_state <= RxIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transceiver.sv
// Bench for uart_transceiver at default parameters (521 clocks per bit).
// TX is checked every cycle against a frame-timeline model; RX against a queue of
// expected bytes with a latency window, plus literal checks per scenario.
`timescale 1ns/1ps

module tb_uart_transceiver;

    localparam int BIT     = 521;
    localparam int FRAME   = 10 * BIT;
    localparam int LAT_MIN = 4940;
    localparam int LAT_MAX = 4966;

    typedef struct {
        logic [7:0] d;
        int         f;
    } rx_exp_t;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       rx_ext    = 1'b1;
    logic       loop      = 1'b0;
    logic       TxD_start = 1'b0;
    logic [7:0] TxD_data  = 8'h00;
    logic       rxd;
    logic       ready;
    logic [7:0] rx_data;
    logic       txd;
    logic       busy;
`ifdef UART_FRAME_ERR_EN
    logic       frame_err;
    int         n_err    = 0;
    int         err_base = 0;
`endif

    int         n_cmp   = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         n_ready = 0;
    rx_exp_t    exp_q[$];

    // Model state
    logic       m_active  = 1'b0;
    int         m_t0      = 0;
    logic [9:0] m_frame   = '0;
    logic [7:0] m_rx_data = '0;

    int         e_cmp;
    int         lat;
    rx_exp_t    x_cmp;
    int         k;
    int         g;
    int         base;
    logic [9:0] a5_bits = '0;
    logic [9:0] exp_a5  = 10'b1101001010;
    logic [7:0] lb[3]   = '{8'h00, 8'hFF, 8'h5A};
    logic [7:0] tb_tx[3] = '{8'hC3, 8'h18, 8'h7E};

    assign rxd = loop ? txd : rx_ext;

    uart_transceiver #(
        .ClkFrequency(10000000),
        .Baud        (19200)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .RxD           (rxd),
        .RxD_data_ready(ready),
        .RxD_data      (rx_data),
        .TxD           (txd),
        .TxD_start     (TxD_start),
        .TxD_data      (TxD_data),
        .TxD_busy      (busy)
`ifdef UART_FRAME_ERR_EN
        ,
        .RxD_frame_err (frame_err)
`endif
    );

    initial forever #5 clk = ~clk;

    initial begin
        #950000;
        $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one 8N1 frame on the external RX line with the given bit length
    task automatic send_rx(input logic [7:0] d, input int bl, input logic stop_bit,
                           input logic valid);
        logic [9:0] fr;
        fr = {stop_bit, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (i == 0 && valid) exp_q.push_back('{d: d, f: cyc - 1});
            rx_ext = fr[i];
            tick(bl);
        end
        rx_ext = 1'b1;
    endtask

    task automatic wait_rx_drained(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_tx_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick(1);
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic send_tx(input logic [7:0] d);
        TxD_data  = d;
        TxD_start = 1'b1;
        tick(1);
        TxD_start = 1'b0;
    endtask

    // Model: a frame accepted at edge t0 shows frame bit (e / BIT) for e in [0, FRAME)
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_active = 1'b0;
        end else begin
            if ((!m_active || (cyc - m_t0) > FRAME) && TxD_start) begin
                m_active = 1'b1;
                m_t0     = cyc;
                m_frame  = {1'b1, TxD_data, 1'b0};
                if (loop) exp_q.push_back('{d: TxD_data, f: cyc});
            end
            cyc++;
        end
    end

    // Per-cycle comparison of all outputs against the model
    initial forever begin
        @(negedge clk);
        e_cmp = cyc - 1 - m_t0;
        if (m_active && e_cmp >= 0 && e_cmp < FRAME) begin
            check("tx_busy", 32'(busy), 32'd1);
            check("tx_line", 32'(txd), 32'(m_frame[4'(e_cmp / BIT)]));
        end else begin
            check("tx_idle_busy", 32'(busy), 32'd0);
            check("tx_idle_line", 32'(txd), 32'd1);
        end
        if (!rst_n) m_rx_data = 8'h00;
        if (ready) begin
            n_ready++;
            if (exp_q.size() == 0) begin
                check("rx_ready_unexpected", 32'(ready), 32'd0);
            end else begin
                x_cmp = exp_q.pop_front();
                check("rx_data_at_ready", 32'(rx_data), 32'(x_cmp.d));
                lat = cyc - 1 - x_cmp.f;
                n_cmp++;
                if (lat < LAT_MIN || lat > LAT_MAX) begin
                    n_fail++;
                    $display("FAIL rx_latency: got %0d clocks, expected %0d..%0d", lat, LAT_MIN,
                             LAT_MAX);
                end
                m_rx_data = x_cmp.d;
            end
        end
        check("rx_data_hold", 32'(rx_data), 32'(m_rx_data));
`ifdef UART_FRAME_ERR_EN
        if (frame_err) n_err++;
`endif
    end

    initial begin
        // Reset state
        tick(4);
        check("reset_txd", 32'(txd), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        rst_n = 1'b1;
        tick(10);

        // Single TX byte A5: busy length and bit-centre levels
        send_tx(8'hA5);
        k = 0;
        while (busy && k < 6000) begin
            if (k % BIT == BIT / 2) a5_bits[4'(k / BIT)] = txd;
            k++;
            tick(1);
        end
        check("a5_busy_clocks", 32'(k), 32'd5210);
        check("a5_bit_levels", 32'(a5_bits), 32'(exp_a5));
        tick(5);

        // Asynchronous reset in the middle of a frame of zeros
        send_tx(8'h00);
        tick(2000);
        check("pre_reset_txd_low", 32'(txd), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_txd", 32'(txd), 32'd1);
        check("async_reset_busy", 32'(busy), 32'd0);
        tick(3);
        rst_n = 1'b1;
        base  = n_ready;
        tick(1000);
        check("post_reset_busy", 32'(busy), 32'd0);
        check("post_reset_no_ready", 32'(n_ready), 32'(base));

        // Back-to-back TX with data changed mid-frame
        TxD_data  = 8'h02;
        TxD_start = 1'b1;
        tick(1000);
        TxD_data = 8'hFF;
        tick(3000);
        TxD_data = 8'h02;
        k = 0;
        while (busy && k < 6000) begin
            tick(1);
            k++;
        end
        g = 0;
        while (!busy && g < 10) begin
            g++;
            tick(1);
        end
        check("b2b_gap_clocks", 32'(g), 32'd1);
        TxD_start = 1'b0;
        wait_tx_idle("b2b_end", 6000);
        tick(5);

        // RX byte 03 at nominal rate
        base = n_ready;
        send_rx(8'h03, BIT, 1'b1, 1'b1);
        wait_rx_drained("rx03_ready", 1000);
        check("rx03_count", 32'(n_ready), 32'(base + 1));
        check("rx03_data", 32'(rx_data), 32'h03);
        tick(1000);
        check("rx03_hold", 32'(rx_data), 32'h03);

        // Short low glitch, under half a bit
        base = n_ready;
`ifdef UART_FRAME_ERR_EN
        err_base = n_err;
`endif
        rx_ext = 1'b0;
        tick(200);
        rx_ext = 1'b1;
        tick(1000);
        check("glitch_no_ready", 32'(n_ready), 32'(base));
`ifdef UART_FRAME_ERR_EN
        check("glitch_frame_err", 32'(n_err), 32'(err_base + 1));
        err_base = n_err;
`endif

        // Frame 81 with a low stop bit
        send_rx(8'h81, BIT, 1'b0, 1'b0);
        tick(1000);
        check("ferr_no_ready", 32'(n_ready), 32'(base));
        check("ferr_data_kept", 32'(rx_data), 32'h03);
`ifdef UART_FRAME_ERR_EN
        check("ferr_frame_err", 32'(n_err), 32'(err_base + 1));
`endif

        // Loopback TxD -> RxD
        loop = 1'b1;
        tick(2);
        base = n_ready;
        foreach (lb[i]) begin
            send_tx(lb[i]);
            wait_tx_idle("loop_tx_done", 6000);
            wait_rx_drained("loop_rx_done", 1000);
            tick(5);
        end
        check("loop_count", 32'(n_ready), 32'(base + 3));
        check("loop_last", 32'(rx_data), 32'h5A);
        loop = 1'b0;
        tick(2);

        // Full duplex: TX frames alongside externally driven RX frames with +/-2% skew
        base = n_ready;
        fork
            begin
                foreach (tb_tx[i]) begin
                    send_tx(tb_tx[i]);
                    wait_tx_idle("duplex_tx_done", 6000);
                    tick(3);
                end
            end
            begin
                send_rx(8'hFF, 511, 1'b1, 1'b1);
                tick(20);
                send_rx(8'h5A, 531, 1'b1, 1'b1);
                tick(20);
                send_rx(8'h00, 521, 1'b1, 1'b1);
            end
        join
        wait_rx_drained("duplex_rx_done", 1000);
        check("duplex_count", 32'(n_ready), 32'(base + 3));
        check("duplex_last", 32'(rx_data), 32'h00);
        check("total_ready", 32'(n_ready), 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
